writeback_ctrl: RTL

- Producer side of the register file write ports. Accepts finished results from the even and odd execution pipes and delays each result by its unit latency.
- Resolves same-target collisions between the two pipes and drives the two write ports (wrt_en_ep/rt_ep_address/rt_value_ep and wrt_en_op/rt_op_address/rt_value_op) from registers.
- Sits between the execution units and the register file, so the register file never sees two writes to the same address in one cycle.

---
 rtl/writeback_ctrl.sv | 128 ++++++++++++
 1 files changed

// File: rtl/writeback_ctrl.sv
// Write-back staging for the even/odd execution pipes: delays each result by its
// unit latency and resolves same-target collisions before the register file ports.
module writeback_ctrl #(
  parameter int unsigned DEPTH  = 7,
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DATA_W = 128
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ep_valid,
  input  logic [ADDR_W-1:0] ep_rt,
  input  logic [DATA_W-1:0] ep_value,
  input  logic [2:0]        ep_lat,
  input  logic              ep_younger,
  input  logic              op_valid,
  input  logic [ADDR_W-1:0] op_rt,
  input  logic [DATA_W-1:0] op_value,
  input  logic [2:0]        op_lat,
  input  logic              op_younger,
  input  logic              flush,
  output logic              wrt_en_ep,
  output logic [ADDR_W-1:0] rt_ep_address,
  output logic [DATA_W-1:0] rt_value_ep,
  output logic              wrt_en_op,
  output logic [ADDR_W-1:0] rt_op_address,
  output logic [DATA_W-1:0] rt_value_op,
  output logic              slot_err,
  output logic              lat_err,
  output logic              coll
);

  typedef struct packed {
    logic              vld;
    logic [ADDR_W-1:0] rt;
    logic [DATA_W-1:0] val;
    logic              yng;
  } entry_t;

  entry_t ep_q [DEPTH];
  entry_t ep_d [DEPTH];
  entry_t op_q [DEPTH];
  entry_t op_d [DEPTH];
  entry_t ep_new;
  entry_t op_new;
  logic   ep_ok;
  logic   op_ok;
  logic   slot_err_q, slot_err_d;
  logic   lat_err_q, lat_err_d;
  logic   coll_q, coll_d;

  always_comb begin
    ep_new = '{vld: 1'b1, rt: ep_rt, val: ep_value, yng: ep_younger};
    op_new = '{vld: 1'b1, rt: op_rt, val: op_value, yng: op_younger};
    ep_ok  = (ep_lat != 3'd0) && (32'(ep_lat) <= DEPTH);
    op_ok  = (op_lat != 3'd0) && (32'(op_lat) <= DEPTH);

    ep_d[0] = '0;
    op_d[0] = '0;
    for (int unsigned s = 1; s < DEPTH; s++) begin
      ep_d[s] = ep_q[s-1];
      op_d[s] = op_q[s-1];
    end

    slot_err_d = 1'b0;
    lat_err_d  = 1'b0;
    coll_d     = 1'b0;

    if (flush) begin
      // The output stage keeps whatever shifted into it this edge.
      for (int unsigned s = 0; s < DEPTH - 1; s++) begin
        ep_d[s] = '0;
        op_d[s] = '0;
      end
    end else begin
      if (ep_valid && !ep_ok) lat_err_d = 1'b1;
      if (op_valid && !op_ok) lat_err_d = 1'b1;
      for (int unsigned s = 0; s < DEPTH; s++) begin
        if (ep_valid && ep_ok && (s == DEPTH - 32'(ep_lat))) begin
          if (ep_d[s].vld) slot_err_d = 1'b1;
          else             ep_d[s]    = ep_new;
        end
        if (op_valid && op_ok && (s == DEPTH - 32'(op_lat))) begin
          if (op_d[s].vld) slot_err_d = 1'b1;
          else             op_d[s]    = op_new;
        end
      end
    end

    // Same-target pair entering the output stages: younger wins, ties go to odd.
    if (ep_d[DEPTH-1].vld && op_d[DEPTH-1].vld &&
        (ep_d[DEPTH-1].rt == op_d[DEPTH-1].rt)) begin
      coll_d = 1'b1;
      if (ep_d[DEPTH-1].yng && !op_d[DEPTH-1].yng) op_d[DEPTH-1].vld = 1'b0;
      else                                         ep_d[DEPTH-1].vld = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned s = 0; s < DEPTH; s++) begin
        ep_q[s] <= '0;
        op_q[s] <= '0;
      end
      slot_err_q <= 1'b0;
      lat_err_q  <= 1'b0;
      coll_q     <= 1'b0;
    end else begin
      for (int unsigned s = 0; s < DEPTH; s++) begin
        ep_q[s] <= ep_d[s];
        op_q[s] <= op_d[s];
      end
      slot_err_q <= slot_err_d;
      lat_err_q  <= lat_err_d;
      coll_q     <= coll_d;
    end
  end

  assign wrt_en_ep     = ep_q[DEPTH-1].vld;
  assign rt_ep_address = ep_q[DEPTH-1].rt;
  assign rt_value_ep   = ep_q[DEPTH-1].val;
  assign wrt_en_op     = op_q[DEPTH-1].vld;
  assign rt_op_address = op_q[DEPTH-1].rt;
  assign rt_value_op   = op_q[DEPTH-1].val;
  assign slot_err      = slot_err_q;
  assign lat_err       = lat_err_q;
  assign coll          = coll_q;

endmodule
